// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared widths, opcodes and FSM encoding for the ALU execute stage
package alu_exec_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR = 3'b110;
  localparam logic [OP_W-1:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - operand-in / write-back-out handshake bundle of the execute stage
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [REG_AW-1:0] dst;
  logic              out_valid;
  logic              out_ready;
  logic              wb_en;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              flag_zero;
  logic              flag_carry;

  modport master (
    output in_valid, op, src_a, src_b, dst, out_ready,
    input  in_ready, out_valid, wb_en, wb_reg, wb_data, flag_zero, flag_carry
  );

  modport slave (
    input  in_valid, op, src_a, src_b, dst, out_ready,
    output in_ready, out_valid, wb_en, wb_reg, wb_data, flag_zero, flag_carry
  );

endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add 8x8->16 multiplier, one multiplier bit per cycle
module alu_mul_seq
  import alu_exec_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic                o_done,
  output logic [2*DATA_W-1:0] o_product
);

  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [2*DATA_W-1:0] r_acc;
  logic [2:0]          r_cnt;
  logic                r_busy;
  logic [2*DATA_W-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Product is exposed combinationally so the parent latches it on the final iteration edge.
  assign o_done    = r_busy && (r_cnt == 3'd7);
  assign o_product = w_acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{DATA_W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU/MUL execute stage feeding register-file write-back
// Optional sequential multiplier for op 111 is enabled by defining ALU_MUL_EN.
module alu_exec_stage
  import alu_exec_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  alu_exec_if.slave bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_mul_path;
  logic              w_mul_done;

  logic [DATA_W-1:0] w_alu_data;
  logic              w_alu_carry;
  logic              w_alu_writes;
  logic              w_alu_zero;
  logic [2:0]        w_sh;

  logic [DATA_W-1:0] r_wb_data;
  logic [REG_AW-1:0] r_wb_reg;
  logic              r_zero;
  logic              r_carry;
  logic              r_writes;

  assign w_accept = bus.in_valid && w_in_ready;

`ifdef ALU_MUL_EN
  logic                w_mul_start;
  logic [2*DATA_W-1:0] w_product;

  assign w_mul_path  = (bus.op == OP_MUL);
  assign w_mul_start = w_accept && w_mul_path;

  alu_mul_seq u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_a       (bus.src_a),
    .i_b       (bus.src_b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );
`else
  assign w_mul_path = 1'b0;
  assign w_mul_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = w_mul_path ? ST_MUL_BUSY : ST_HOLD;
        end
      end
      ST_MUL_BUSY: begin
        if (w_mul_done) begin
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          if (w_accept) begin
            w_next_state = w_mul_path ? ST_MUL_BUSY : ST_HOLD;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = !reset && ((r_state == ST_IDLE) ||
                             ((r_state == ST_HOLD) && bus.out_ready));
    w_out_valid = (r_state == ST_HOLD);
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.wb_en      = w_out_valid && bus.out_ready && r_writes;
  assign bus.wb_reg     = r_wb_reg;
  assign bus.wb_data    = r_wb_data;
  assign bus.flag_zero  = r_zero;
  assign bus.flag_carry = r_carry;

  // Shifts go through a 9-bit window so the last bit shifted out lands in the carry slot.
  always_comb begin
    w_alu_data   = '0;
    w_alu_carry  = 1'b0;
    w_alu_writes = 1'b1;
    w_sh         = bus.src_b[2:0];
    case (bus.op)
      OP_ADD: {w_alu_carry, w_alu_data} = {1'b0, bus.src_a} + {1'b0, bus.src_b};
      OP_SUB: begin
        w_alu_data  = bus.src_a - bus.src_b;
        w_alu_carry = (bus.src_a < bus.src_b);
      end
      OP_AND: w_alu_data = bus.src_a & bus.src_b;
      OP_OR:  w_alu_data = bus.src_a | bus.src_b;
      OP_XOR: w_alu_data = bus.src_a ^ bus.src_b;
      OP_SHL: {w_alu_carry, w_alu_data} = {1'b0, bus.src_a} << w_sh;
      OP_SHR: {w_alu_data, w_alu_carry} = {bus.src_a, 1'b0} >> w_sh;
      default: w_alu_writes = 1'b0;
    endcase
    w_alu_zero = w_alu_writes && (w_alu_data == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_data <= '0;
      r_wb_reg  <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_writes  <= 1'b0;
    end else if (w_accept && !w_mul_path) begin
      r_wb_data <= w_alu_data;
      r_wb_reg  <= bus.dst;
      r_zero    <= w_alu_zero;
      r_carry   <= w_alu_carry;
      r_writes  <= w_alu_writes;
    end else if (w_accept) begin
      r_wb_reg  <= bus.dst;
`ifdef ALU_MUL_EN
    end else if (w_mul_done) begin
      r_wb_data <= w_product[DATA_W-1:0];
      r_zero    <= (w_product[DATA_W-1:0] == '0);
      r_carry   <= (w_product[2*DATA_W-1:DATA_W] != '0);
      r_writes  <= 1'b1;
`endif
    end
  end

endmodule
